// File: rtl/alu_stage_pkg.sv
// rtl/alu_stage_pkg.sv - shared codes, flag indices and entry sizing for alu_result_stage
package alu_stage_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLT  = 3'b011,
    BR_BGE  = 3'b100,
    BR_BLTU = 3'b101,
    BR_BGEU = 3'b110,
    BR_JAL  = 3'b111
  } br_op_e;

  localparam int FLAG_EQ  = 0;
  localparam int FLAG_LT  = 1;
  localparam int FLAG_LTU = 2;

  typedef enum logic [2:0] {
    SUB  = 3'd0,
    ADD  = 3'd1,
    AND  = 3'd2,
    OR   = 3'd3,
    XOR  = 3'd4,
    RMV  = 3'd5,
    LMV  = 3'd6,
    ARMV = 3'd7
  } alu_sel_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  // Entry = {result, target, rd, wb_en, taken, error}
  localparam int ENTRY_BITS_W = 3;

  function automatic int entry_w(input int width, input int rd_w);
    return 2 * width + rd_w + ENTRY_BITS_W;
  endfunction

endpackage

// File: rtl/alu_result_stage_branch_cond.sv
// rtl/alu_result_stage_branch_cond.sv - branch/jump taken decision from compare flags
module branch_cond
  import alu_stage_pkg::*;
(
  input  logic [2:0] br_op,
  input  logic [2:0] flag,
  input  logic       error,
  output logic       taken
);

  logic cond;

  always_comb begin
    cond = 1'b0;
    case (br_op_e'(br_op))
      BR_BEQ:  cond = flag[FLAG_EQ];
      BR_BNE:  cond = !flag[FLAG_EQ];
      BR_BLT:  cond = flag[FLAG_LT];
      BR_BGE:  cond = !flag[FLAG_LT];
      BR_BLTU: cond = flag[FLAG_LTU];
      BR_BGEU: cond = !flag[FLAG_LTU];
      BR_JAL:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
    taken = cond && !error;
  end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - EX/MEM result register with branch resolve and 2-entry skid buffer
// Optional ALU_STAGE_STATS_EN adds saturating taken/error transfer counters.
module alu_result_stage
  import alu_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_ans,
  input  logic [2:0]       alu_flag,
  input  logic             alu_error,
  input  logic [2:0]       in_br_op,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             in_wb_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_wb_en,
  output logic             out_br_taken,
  output logic [WIDTH-1:0] out_br_target,
  output logic             out_error
`ifdef ALU_STAGE_STATS_EN
  ,
  output logic [31:0]      stat_taken,
  output logic [31:0]      stat_error
`endif
);

  localparam int EW = entry_w(WIDTH, RD_W);

  stage_state_e state_q, state_d;
  logic [EW-1:0] main_q, skid_q, in_entry;
  logic accept, transfer, load_main, load_skid, move_skid;
  logic taken;
  logic [WIDTH-1:0] result, target;
  logic wb_en;

  branch_cond u_branch_cond (
    .br_op (in_br_op),
    .flag  (alu_flag),
    .error (alu_error),
    .taken (taken)
  );

  // An erroring JAL still reports alu_ans rather than the link address.
  assign result   = (!alu_error && in_br_op == BR_JAL) ? in_pc + WIDTH'(4) : alu_ans;
  assign target   = in_pc + in_imm;
  assign wb_en    = in_wb_en && !alu_error && (in_rd != '0);
  assign in_entry = {result, target, in_rd, wb_en, taken, alu_error};

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign transfer  = out_valid && out_ready;

  assign {out_result, out_br_target, out_rd, out_wb_en, out_br_taken, out_error} = main_q;

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_ONE;
            load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !transfer) begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
          end else if (accept && transfer) begin
            load_main = 1'b1;
          end else if (transfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (transfer) begin
            state_d   = ST_ONE;
            move_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_main) begin
        main_q <= in_entry;
      end else if (move_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_entry;
      end
    end
  end

`ifdef ALU_STAGE_STATS_EN
  logic counted;
  assign counted = transfer && !flush;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_taken <= '0;
      stat_error <= '0;
    end else if (counted) begin
      if (out_br_taken && stat_taken != 32'hFFFF_FFFF) begin
        stat_taken <= stat_taken + 32'd1;
      end
      if (out_error && stat_error != 32'hFFFF_FFFF) begin
        stat_error <= stat_error + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - scoreboard bench for alu_result_stage with directed vectors
module tb_alu_result_stage;
  import alu_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rstn, flush, in_valid, in_ready;
  logic [31:0] alu_ans, in_pc, in_imm;
  logic [2:0]  alu_flag, in_br_op;
  logic        alu_error, in_wb_en;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready;
  logic [31:0] out_result, out_br_target;
  logic [4:0]  out_rd;
  logic        out_wb_en, out_br_taken, out_error;
`ifdef ALU_STAGE_STATS_EN
  logic [31:0] stat_taken, stat_error;
`endif

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(32), .RD_W(5)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_ans       (alu_ans),
    .alu_flag      (alu_flag),
    .alu_error     (alu_error),
    .in_br_op      (in_br_op),
    .in_pc         (in_pc),
    .in_imm        (in_imm),
    .in_rd         (in_rd),
    .in_wb_en      (in_wb_en),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_rd        (out_rd),
    .out_wb_en     (out_wb_en),
    .out_br_taken  (out_br_taken),
    .out_br_target (out_br_target),
    .out_error     (out_error)
`ifdef ALU_STAGE_STATS_EN
    ,
    .stat_taken    (stat_taken),
    .stat_error    (stat_error)
`endif
  );

  typedef struct {
    logic [31:0] result;
    logic [31:0] target;
    logic [4:0]  rd;
    logic        wb;
    logic        taken;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  logic bg_done;

  function automatic exp_t mk(logic [31:0] r, logic [31:0] t, logic [4:0] rd, logic wb, logic tk, logic er);
    exp_t e;
    e.result = r; e.target = t; e.rd = rd; e.wb = wb; e.taken = tk; e.err = er;
    return e;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [2:0] op, logic [2:0] flg, logic err, logic [31:0] ans,
                      logic [31:0] pc, logic [31:0] imm, logic [4:0] rd, logic wb, exp_t e);
    int n = 0;
    in_valid = 1'b1; in_br_op = op; alu_flag = flg; alu_error = err; alu_ans = ans;
    in_pc = pc; in_imm = imm; in_rd = rd; in_wb_en = wb;
    while (1) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        break;
      end
      n++;
      if (n > 50) begin
        check("accept_timeout", {127'd0, in_ready}, 128'd1);
        in_valid = 1'b0;
        return;
      end
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(string name);
    int n = 0;
    while ((sb.size() != 0 || !bg_done) && n < 60) begin
      tick();
      n++;
    end
    check(name, 128'(sb.size()), 128'd0);
  endtask

  // Monitor: pops on every presented transfer, and checks outputs hold while stalled.
  logic         prev_stall = 1'b0;
  logic [127:0] prev_vec = '0;
  logic [127:0] cur_vec;
  exp_t         me;

  always @(negedge clk) begin
    cur_vec = {56'd0, out_result, out_br_target, out_rd, out_wb_en, out_br_taken, out_error};
    if (rstn && !flush && out_valid) begin
      if (prev_stall) check("hold_stable", cur_vec, prev_vec);
      if (out_ready) begin
        check("queue_nonempty", {127'd0, sb.size() != 0}, 128'd1);
        if (sb.size() != 0) begin
          me = sb.pop_front();
          check("entry", cur_vec, {56'd0, me.result, me.target, me.rd, me.wb, me.taken, me.err});
        end
      end
    end
    prev_stall = rstn && !flush && out_valid && !out_ready;
    prev_vec   = cur_vec;
  end

  initial begin
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_ans = 32'hFFFF_FFFF; in_pc = 32'hFFFF_FFFF; in_imm = 32'hFFFF_FFFF;
    alu_flag = 3'b111; alu_error = 1'b1; in_br_op = 3'b111; in_rd = 5'h1F; in_wb_en = 1'b1;
    bg_done = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("reset_out_valid", {127'd0, out_valid}, 128'd0);
    check("reset_in_ready", {127'd0, in_ready}, 128'd1);
    check("reset_data", {56'd0, out_result, out_br_target, out_rd, out_wb_en, out_br_taken, out_error}, 128'd0);
    tick();
    rstn = 1'b1;

    // Single BEQ taken, one-cycle latency
    out_ready = 1'b1;
    send(BR_BEQ, 3'b001, 1'b0, 32'h55, 32'h100, 32'h20, 5'd3, 1'b1, mk(32'h55, 32'h120, 5'd3, 1'b1, 1'b1, 1'b0));
    @(negedge clk);
    check("latency_out_valid", {127'd0, out_valid}, 128'd1);
    check("beq_taken", {127'd0, out_br_taken}, 128'd1);
    check("beq_target", 128'(out_br_target), 128'h120);
    drain("drain_beq");

    // Four back-to-back with a stalled consumer
    out_ready = 1'b0;
    send(BR_NONE, 3'b000, 1'b0, 32'hA1, 32'h10, 32'h4, 5'd1, 1'b1, mk(32'hA1, 32'h14, 5'd1, 1'b1, 1'b0, 1'b0));
    send(BR_NONE, 3'b000, 1'b0, 32'hA2, 32'h20, 32'h4, 5'd2, 1'b1, mk(32'hA2, 32'h24, 5'd2, 1'b1, 1'b0, 1'b0));
    bg_done = 1'b0;
    fork
      begin
        send(BR_NONE, 3'b000, 1'b0, 32'hA3, 32'h30, 32'h4, 5'd3, 1'b1, mk(32'hA3, 32'h34, 5'd3, 1'b1, 1'b0, 1'b0));
        send(BR_NONE, 3'b000, 1'b0, 32'hA4, 32'h40, 32'h4, 5'd4, 1'b0, mk(32'hA4, 32'h44, 5'd4, 1'b0, 1'b0, 1'b0));
        bg_done = 1'b1;
      end
    join_none
    tick();
    tick();
    @(negedge clk);
    check("full_in_ready", {127'd0, in_ready}, 128'd0);
    check("full_queued", 128'(sb.size()), 128'd2);
    tick();
    out_ready = 1'b1;
    drain("drain_b2b");

    // Condition coverage
    send(BR_BLTU, 3'b010, 1'b0, 32'h5, 32'h200, 32'h10, 5'd1, 1'b1, mk(32'h5, 32'h210, 5'd1, 1'b1, 1'b0, 1'b0));
    send(BR_BLT, 3'b010, 1'b0, 32'h6, 32'h300, 32'hFFFF_FFF0, 5'd2, 1'b1, mk(32'h6, 32'h2F0, 5'd2, 1'b1, 1'b1, 1'b0));
    send(BR_JAL, 3'b000, 1'b0, 32'h9, 32'hFFFF_FFFC, 32'h8, 5'd1, 1'b1, mk(32'h0, 32'h4, 5'd1, 1'b1, 1'b1, 1'b0));
    send(BR_BNE, 3'b001, 1'b0, 32'h7, 32'h40, 32'h8, 5'd4, 1'b1, mk(32'h7, 32'h48, 5'd4, 1'b1, 1'b0, 1'b0));
    send(BR_BGE, 3'b000, 1'b0, 32'h8, 32'h50, 32'h8, 5'd5, 1'b0, mk(32'h8, 32'h58, 5'd5, 1'b0, 1'b1, 1'b0));
    send(BR_BGEU, 3'b100, 1'b0, 32'h9, 32'h60, 32'h8, 5'd6, 1'b1, mk(32'h9, 32'h68, 5'd6, 1'b1, 1'b0, 1'b0));
    send(BR_BEQ, 3'b110, 1'b0, 32'hA, 32'h70, 32'h8, 5'd0, 1'b1, mk(32'hA, 32'h78, 5'd0, 1'b0, 1'b0, 1'b0));
    send(BR_BEQ, 3'b001, 1'b1, 32'hDEAD, 32'h80, 32'h8, 5'd7, 1'b1, mk(32'hDEAD, 32'h88, 5'd7, 1'b0, 1'b0, 1'b1));
    send(BR_JAL, 3'b000, 1'b1, 32'hBEEF, 32'h90, 32'h8, 5'd8, 1'b1, mk(32'hBEEF, 32'h98, 5'd8, 1'b0, 1'b0, 1'b1));
    drain("drain_cond");

    // Flush while FULL with a new entry offered
    out_ready = 1'b0;
    send(BR_NONE, 3'b000, 1'b0, 32'hB1, 32'h0, 32'h0, 5'd1, 1'b1, mk(32'hB1, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0));
    send(BR_NONE, 3'b000, 1'b0, 32'hB2, 32'h0, 32'h0, 5'd2, 1'b1, mk(32'hB2, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0));
    in_valid = 1'b1; alu_ans = 32'hBAD; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_out_valid", {127'd0, out_valid}, 128'd0);
    check("flush_in_ready", {127'd0, in_ready}, 128'd1);
    tick();
    out_ready = 1'b1;
    repeat (3) tick();
    send(BR_BNE, 3'b000, 1'b0, 32'hC1, 32'h1000, 32'h10, 5'd9, 1'b1, mk(32'hC1, 32'h1010, 5'd9, 1'b1, 1'b1, 1'b0));
    drain("drain_after_flush");

    // Reset while FULL and stalled
    out_ready = 1'b0;
    send(BR_JAL, 3'b000, 1'b0, 32'hD1, 32'h2000, 32'h40, 5'd3, 1'b1, mk(32'h2004, 32'h2040, 5'd3, 1'b1, 1'b1, 1'b0));
    send(BR_BEQ, 3'b001, 1'b1, 32'hD2, 32'h3000, 32'h40, 5'd4, 1'b1, mk(32'hD2, 32'h3040, 5'd4, 1'b0, 1'b0, 1'b1));
    rstn = 1'b0;
    tick();
    sb.delete();
    @(negedge clk);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);
    check("rst_data", {56'd0, out_result, out_br_target, out_rd, out_wb_en, out_br_taken, out_error}, 128'd0);
`ifdef ALU_STAGE_STATS_EN
    check("rst_stat_taken", 128'(stat_taken), 128'd0);
    check("rst_stat_error", 128'(stat_error), 128'd0);
`endif
    tick();
    rstn = 1'b1;
    out_ready = 1'b1;
    send(BR_BLTU, 3'b100, 1'b0, 32'hE1, 32'h10, 32'h20, 5'd5, 1'b1, mk(32'hE1, 32'h30, 5'd5, 1'b1, 1'b1, 1'b0));
    drain("drain_after_reset");
`ifdef ALU_STAGE_STATS_EN
    check("stat_taken_count", 128'(stat_taken), 128'd1);
    check("stat_error_count", 128'(stat_error), 128'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
